// File: rtl/nec_ir_rx_if.sv
// Signal bundle between the NEC IR decoder and its keypad-style consumers.
// The decoder is the master; consumers such as the timer entry logic use the slave view.
interface nec_ir_rx_if;
   logic       ir_in;
   logic [7:0] addr;
   logic [7:0] cmd;
   logic [3:0] set_time;
   logic       ir_ready;
   logic       ir_repeat;
   logic       frame_err;

   modport master (
      input  ir_in,
      output addr, cmd, set_time, ir_ready, ir_repeat, frame_err
   );

   modport slave (
      output ir_in,
      input  addr, cmd, set_time, ir_ready, ir_repeat, frame_err
   );
endinterface

// File: rtl/nec_ir_rx.sv
// NEC IR frame decoder: times marks and spaces in microseconds, assembles the 32-bit
// frame, validates the inverted bytes and maps the command byte to a 4-bit key code.
module nec_ir_rx #(
   parameter int CLK_PER_US = 50,
   parameter bit CHECK_ADDR = 1'b1
) (
   input logic         clk_in,
   input logic         rst,
   nec_ir_rx_if.master ir
);

   localparam int            PW       = (CLK_PER_US > 1) ? $clog2(CLK_PER_US) : 1;
   localparam logic [PW-1:0] PRE_LAST = PW'(CLK_PER_US - 1);

   localparam logic [15:0] LEAD_MARK_MIN  = 16'd8000;
   localparam logic [15:0] LEAD_MARK_MAX  = 16'd10000;
   localparam logic [15:0] LEAD_SPACE_MIN = 16'd4000;
   localparam logic [15:0] LEAD_SPACE_MAX = 16'd5000;
   localparam logic [15:0] RPT_SPACE_MIN  = 16'd2000;
   localparam logic [15:0] RPT_SPACE_MAX  = 16'd2500;
   localparam logic [15:0] BIT_MIN        = 16'd400;
   localparam logic [15:0] BIT_MAX        = 16'd700;
   localparam logic [15:0] ONE_MIN        = 16'd1400;
   localparam logic [15:0] ONE_MAX        = 16'd1900;
   localparam logic [15:0] TIMEOUT        = 16'd12000;

   typedef enum logic [2:0] {
      S_IDLE,
      S_LEAD_MARK,
      S_LEAD_SPACE,
      S_BIT_MARK,
      S_BIT_SPACE
   } state_t;

   function automatic logic in_range(input logic [15:0] w, input logic [15:0] lo,
                                     input logic [15:0] hi);
      return (w >= lo) && (w <= hi);
   endfunction

   function automatic logic [3:0] key_map(input logic [7:0] c);
      case (c)
         8'h16:   return 4'd0;
         8'h0C:   return 4'd1;
         8'h18:   return 4'd2;
         8'h5E:   return 4'd3;
         8'h08:   return 4'd4;
         8'h1C:   return 4'd5;
         8'h5A:   return 4'd6;
         8'h42:   return 4'd7;
         8'h52:   return 4'd8;
         8'h4A:   return 4'd9;
         8'h44:   return 4'hF;
         default: return 4'hE;
      endcase
   endfunction

   logic          sync1, sync2, sync3;
   logic          fall_q, rise_q;
   logic [PW-1:0] pre_cnt;
   logic          us_tick;
   logic [15:0]   width_cnt;
   logic [15:0]   width_now;
   logic          bit_zero, bit_one;
   logic [30:0]   shift_q;
   logic [31:0]   frame_next;
   logic          frame_ok;
   logic [4:0]    bit_cnt;
   logic          last_ok;
   state_t        state;

   // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
   // The synchroniser resets to the idle-high level so reset release never fakes a mark.
   always_ff @(posedge clk_in or negedge rst) begin
      if (!rst) begin
         sync1  <= 1'b1;
         sync2  <= 1'b1;
         sync3  <= 1'b1;
         fall_q <= 1'b0;
         rise_q <= 1'b0;
      end else begin
         sync1  <= ir.ir_in;
         sync2  <= sync1;
         sync3  <= sync2;
         fall_q <= sync3 & ~sync2;
         rise_q <= ~sync3 & sync2;
      end
   end

   assign us_tick = (pre_cnt == PRE_LAST);

   // Counting the tick of the edge cycle itself makes the judged width exact for any prescaler phase.
   assign width_now = (us_tick && (width_cnt != 16'hFFFF)) ? width_cnt + 16'd1 : width_cnt;

   always_ff @(posedge clk_in or negedge rst) begin
      if (!rst) begin
         pre_cnt   <= '0;
         width_cnt <= '0;
      end else begin
         pre_cnt   <= us_tick ? '0 : pre_cnt + PW'(1);
         width_cnt <= (fall_q | rise_q) ? 16'd0 : width_now;
      end
   end

   assign bit_zero   = in_range(width_now, BIT_MIN, BIT_MAX);
   assign bit_one    = in_range(width_now, ONE_MIN, ONE_MAX);
   assign frame_next = {bit_one, shift_q};
   assign frame_ok   = (frame_next[31:24] == ~frame_next[23:16]) &&
                       (!CHECK_ADDR || (frame_next[15:8] == ~frame_next[7:0]));

   always_ff @(posedge clk_in or negedge rst) begin
      if (!rst) begin
         state        <= S_IDLE;
         bit_cnt      <= '0;
         shift_q      <= '0;
         last_ok      <= 1'b0;
         ir.addr      <= '0;
         ir.cmd       <= '0;
         ir.set_time  <= '0;
         ir.ir_ready  <= 1'b0;
         ir.ir_repeat <= 1'b0;
         ir.frame_err <= 1'b0;
      end else begin
         ir.ir_ready  <= 1'b0;
         ir.ir_repeat <= 1'b0;
         ir.frame_err <= 1'b0;
         if ((state != S_IDLE) && (width_cnt > TIMEOUT)) begin
            ir.frame_err <= 1'b1;
            last_ok      <= 1'b0;
            state        <= S_IDLE;
         end else begin
            case (state)
               S_IDLE: if (fall_q) state <= S_LEAD_MARK;
               S_LEAD_MARK: if (rise_q) begin
                  if (in_range(width_now, LEAD_MARK_MIN, LEAD_MARK_MAX)) begin
                     state <= S_LEAD_SPACE;
                  end else begin
                     ir.frame_err <= 1'b1;
                     last_ok      <= 1'b0;
                     state        <= S_IDLE;
                  end
               end
               S_LEAD_SPACE: if (fall_q) begin
                  if (in_range(width_now, LEAD_SPACE_MIN, LEAD_SPACE_MAX)) begin
                     bit_cnt <= '0;
                     shift_q <= '0;
                     state   <= S_BIT_MARK;
                  end else if (in_range(width_now, RPT_SPACE_MIN, RPT_SPACE_MAX)) begin
                     ir.ir_repeat <= last_ok;
                     state        <= S_IDLE;
                  end else begin
                     ir.frame_err <= 1'b1;
                     last_ok      <= 1'b0;
                     state        <= S_IDLE;
                  end
               end
               S_BIT_MARK: if (rise_q) begin
                  if (in_range(width_now, BIT_MIN, BIT_MAX)) begin
                     state <= S_BIT_SPACE;
                  end else begin
                     ir.frame_err <= 1'b1;
                     last_ok      <= 1'b0;
                     state        <= S_IDLE;
                  end
               end
               S_BIT_SPACE: if (fall_q) begin
                  if (bit_zero || bit_one) begin
                     shift_q <= frame_next[31:1];
                     if (bit_cnt == 5'd31) begin
                        state <= S_IDLE;
                        if (frame_ok) begin
                           ir.addr     <= frame_next[7:0];
                           ir.cmd      <= frame_next[23:16];
                           ir.set_time <= key_map(frame_next[23:16]);
                           ir.ir_ready <= 1'b1;
                           last_ok     <= 1'b1;
                        end else begin
                           ir.frame_err <= 1'b1;
                           last_ok      <= 1'b0;
                        end
                     end else begin
                        bit_cnt <= bit_cnt + 5'd1;
                        state   <= S_BIT_MARK;
                     end
                  end else begin
                     ir.frame_err <= 1'b1;
                     last_ok      <= 1'b0;
                     state        <= S_IDLE;
                  end
               end
               default: state <= S_IDLE;
            endcase
         end
      end
   end

endmodule

// File: tb/tb_nec_ir_rx.sv
// Bench for nec_ir_rx: two decoders (address check on and off) share one IR line and are
// compared against a frame-level model of the NEC protocol rules.
module tb_nec_ir_rx;

   localparam int CPU = 1;
   localparam logic [7:0] KEYS [10] = '{8'h16, 8'h0C, 8'h18, 8'h5E, 8'h08,
                                        8'h1C, 8'h5A, 8'h42, 8'h52, 8'h4A};

   logic clk_in = 1'b0;
   logic rst    = 1'b0;
   logic ir     = 1'b1;

   always #5 clk_in = ~clk_in;

   nec_ir_rx_if bus_a ();
   nec_ir_rx_if bus_b ();
   assign bus_a.ir_in = ir;
   assign bus_b.ir_in = ir;

   nec_ir_rx #(.CLK_PER_US(CPU), .CHECK_ADDR(1'b1)) u_chk (.clk_in(clk_in), .rst(rst), .ir(bus_a));
   nec_ir_rx #(.CLK_PER_US(CPU), .CHECK_ADDR(1'b0)) u_ext (.clk_in(clk_in), .rst(rst), .ir(bus_b));

   int n_checks = 0;
   int n_errors = 0;

   int cyc = 0;
   always @(posedge clk_in) cyc <= cyc + 1;

   // Strobe monitor: counts pulses and flags overlapping or multi-cycle strobes.
   int         n_rdy [2] = '{0, 0};
   int         n_rep [2] = '{0, 0};
   int         n_err [2] = '{0, 0};
   int         viol      = 0;
   int         rdy_cyc   = 0;
   logic [2:0] st_a, st_b;
   logic [2:0] prev_a = '0;
   logic [2:0] prev_b = '0;
   assign st_a = {bus_a.ir_ready, bus_a.ir_repeat, bus_a.frame_err};
   assign st_b = {bus_b.ir_ready, bus_b.ir_repeat, bus_b.frame_err};

   always @(negedge clk_in) begin
      if (st_a[2]) begin n_rdy[0] <= n_rdy[0] + 1; rdy_cyc <= cyc; end
      if (st_a[1]) n_rep[0] <= n_rep[0] + 1;
      if (st_a[0]) n_err[0] <= n_err[0] + 1;
      if (st_b[2]) n_rdy[1] <= n_rdy[1] + 1;
      if (st_b[1]) n_rep[1] <= n_rep[1] + 1;
      if (st_b[0]) n_err[1] <= n_err[1] + 1;
      if ($countones(st_a) > 1 || $countones(st_b) > 1 ||
          (st_a & prev_a) != 3'b000 || (st_b & prev_b) != 3'b000)
         viol <= viol + 1;
      prev_a <= st_a;
      prev_b <= st_b;
   end

   // Reference model, one slot per decoder (0: address checked, 1: extended addressing).
   logic [7:0] m_addr [2] = '{8'h00, 8'h00};
   logic [7:0] m_cmd  [2] = '{8'h00, 8'h00};
   logic [3:0] m_key  [2] = '{4'h0, 4'h0};
   bit         m_ok   [2] = '{1'b0, 1'b0};
   int         e_rdy  [2] = '{0, 0};
   int         e_rep  [2] = '{0, 0};
   int         e_err  [2] = '{0, 0};
   int         last_edge = 0;

   function automatic logic [3:0] key_of(input logic [7:0] c);
      for (int i = 0; i < 10; i++)
         if (KEYS[i] == c) return 4'(i);
      return (c == 8'h44) ? 4'hF : 4'hE;
   endfunction

   function automatic logic [31:0] mk(input logic [7:0] a, input logic [7:0] ai,
                                      input logic [7:0] c, input logic [7:0] ci);
      return {ci, c, ai, a};
   endfunction

   task automatic m_frame(input logic [31:0] w);
      for (int d = 0; d < 2; d++) begin
         bit ok;
         ok = (w[31:24] == ~w[23:16]) && ((d == 1) || (w[15:8] == ~w[7:0]));
         if (ok) begin
            e_rdy[d]++;
            m_addr[d] = w[7:0];
            m_cmd[d]  = w[23:16];
            m_key[d]  = key_of(w[23:16]);
         end else begin
            e_err[d]++;
         end
         m_ok[d] = ok;
      end
   endtask

   task automatic m_repeat();
      for (int d = 0; d < 2; d++)
         if (m_ok[d]) e_rep[d]++;
   endtask

   task automatic m_error();
      for (int d = 0; d < 2; d++) begin
         e_err[d]++;
         m_ok[d] = 1'b0;
      end
   endtask

   task automatic m_reset();
      for (int d = 0; d < 2; d++) begin
         m_addr[d] = '0;
         m_cmd[d]  = '0;
         m_key[d]  = '0;
         m_ok[d]   = 1'b0;
      end
   endtask

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_checks++;
      assert (obs === exp)
      else begin
         n_errors++;
         $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
      end
   endtask

   function automatic logic [19:0] outs(input int d);
      if (d == 0) return {bus_a.addr, bus_a.cmd, bus_a.set_time};
      return {bus_b.addr, bus_b.cmd, bus_b.set_time};
   endfunction

   task automatic check_all(input string tag);
      for (int d = 0; d < 2; d++) begin
         string      nm;
         logic [19:0] o;
         nm = {tag, (d == 0) ? "/chk" : "/ext"};
         o  = outs(d);
         check({nm, "/addr"},     32'(o[19:12]), 32'(m_addr[d]));
         check({nm, "/cmd"},      32'(o[11:4]),  32'(m_cmd[d]));
         check({nm, "/set_time"}, 32'(o[3:0]),   32'(m_key[d]));
         check({nm, "/n_ready"},  32'(n_rdy[d]), 32'(e_rdy[d]));
         check({nm, "/n_repeat"}, 32'(n_rep[d]), 32'(e_rep[d]));
         check({nm, "/n_err"},    32'(n_err[d]), 32'(e_err[d]));
      end
   endtask

   task automatic pulse(input logic lvl, input int us);
      ir = lvl;
      repeat (us * CPU) @(negedge clk_in);
   endtask

   function automatic int pick(input bit rnd, input int lo, input int hi, input int fixed);
      return rnd ? int'($urandom_range(hi, lo)) : fixed;
   endfunction

   task automatic send_bits(input logic [31:0] w, input int n, input int one_lo, input int one_hi,
                            input int zero_lo, input int zero_hi, input bit rnd);
      for (int i = 0; i < n; i++) begin
         pulse(1'b0, pick(rnd, 400, 700, 560));
         if (w[i]) pulse(1'b1, pick(rnd, 1400, 1900, (i % 2 == 1) ? one_hi : one_lo));
         else      pulse(1'b1, pick(rnd, 400, 700, (i % 2 == 1) ? zero_hi : zero_lo));
      end
   endtask

   task automatic send_frame(input logic [31:0] w, input int lead_mark, input int one_lo,
                             input int one_hi, input int zero_lo, input int zero_hi, input bit rnd);
      pulse(1'b0, lead_mark);
      pulse(1'b1, 4500);
      send_bits(w, 32, one_lo, one_hi, zero_lo, zero_hi, rnd);
      last_edge = cyc;
      pulse(1'b0, 560);
      pulse(1'b1, 200);
   endtask

   task automatic send_repeat();
      pulse(1'b0, 9000);
      pulse(1'b1, 2250);
      pulse(1'b0, 560);
      pulse(1'b1, 200);
   endtask

   initial begin
      logic [31:0] w;
      logic [7:0]  a, c;
      int          k;

      repeat (5) @(negedge clk_in);
      check_all("reset");
      check("reset/strobes", 32'({st_a, st_b}), 32'd0);
      rst = 1'b1;
      repeat (10) @(negedge clk_in);

      send_repeat();
      m_repeat();
      check_all("repeat_no_frame");

      w = mk(8'h00, 8'hFF, 8'h18, 8'hE7);
      send_frame(w, 9000, 1690, 1690, 560, 560, 1'b0);
      m_frame(w);
      check_all("frame_18");
      check("frame_18/latency", 32'(rdy_cyc - last_edge), 32'd4);

      pulse(1'b1, 40000);
      send_repeat();
      m_repeat();
      check_all("repeat_after_frame");

      for (int r = 0; r < 2; r++) begin
         a = 8'($urandom);
         k = int'($urandom_range(11, 0));
         c = (k < 10) ? KEYS[k] : ((k == 10) ? 8'h44 : 8'($urandom));
         w = mk(a, ~a, c, ~c);
         send_frame(w, 9000, 0, 0, 0, 0, 1'b1);
         m_frame(w);
         check_all($sformatf("random_%0d", r));
      end

      w = mk(8'h20, 8'hDF, 8'h0C, 8'hF2);
      send_frame(w, 9000, 1690, 1690, 560, 560, 1'b0);
      m_frame(w);
      check_all("bad_cmd_inv");
      send_repeat();
      m_repeat();
      check_all("repeat_after_bad");

      w = mk(8'h12, 8'h34, 8'h5A, 8'hA5);
      send_frame(w, 9000, 1690, 1690, 560, 560, 1'b0);
      m_frame(w);
      check_all("ext_addr");

      w = mk(8'h55, 8'hAA, 8'h42, 8'hBD);
      send_frame(w, 8000, 1400, 1900, 400, 700, 1'b0);
      m_frame(w);
      check_all("bounds_1400_1900_lead8000");

      pulse(1'b0, 9000);
      pulse(1'b1, 4500);
      send_bits(32'h0000_001F, 5, 1690, 1690, 560, 560, 1'b0);
      pulse(1'b0, 560);
      pulse(1'b1, 1950);
      pulse(1'b0, 560);
      pulse(1'b1, 300);
      m_error();
      check_all("space_1950");

      pulse(1'b0, 7990);
      pulse(1'b1, 300);
      m_error();
      check_all("lead_mark_7990");

      pulse(1'b0, 9000);
      pulse(1'b1, 4500);
      pulse(1'b0, 13000);
      pulse(1'b1, 300);
      m_error();
      check_all("timeout");

      pulse(1'b0, 9000);
      pulse(1'b1, 4500);
      send_bits(32'h5A5A_5A5A, 16, 1690, 1690, 560, 560, 1'b0);
      pulse(1'b0, 200);
      rst = 1'b0;
      #1;
      m_reset();
      check_all("reset_bit17");
      check("reset_bit17/strobes", 32'({st_a, st_b}), 32'd0);
      ir = 1'b1;
      repeat (20) @(negedge clk_in);
      rst = 1'b1;
      repeat (20) @(negedge clk_in);
      check_all("after_reset");

      w = mk(8'h00, 8'hFF, 8'h44, 8'hBB);
      send_frame(w, 9000, 1690, 1690, 560, 560, 1'b0);
      m_frame(w);
      check_all("start_key");
      check("start_key/set_time", 32'(bus_a.set_time), 32'hF);

      check("strobe_exclusive_1cycle", 32'(viol), 32'd0);

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

   initial begin
      #(20_000_000);
      n_errors++;
      $display("FAIL watchdog: simulation time limit reached");
      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $fatal(1, "watchdog expired");
   end

endmodule
